inst_loader: RTL and testbench



---
 rtl/inst_loader.sv | 137 +++++++++++++
 tb/tb_inst_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: streams a little-endian byte image into instruction memory, holding the CPU in reset until loaded.
// Optional trailing XOR checksum byte with CKS/ERR states and err port when INST_LOADER_CHECKSUM_EN is defined.
module inst_loader #(
    parameter int CPU_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      mem_wen,
    output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
    output logic [CPU_WIDTH-1:0]      mem_wdata,
    output logic                      cpu_rst_n,
    output logic                      done,
    output logic                      ovf
`ifdef INST_LOADER_CHECKSUM_EN
    ,
    output logic                      err
`endif
);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CKS, ERR, DONE} state_t;

`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_t TAIL = CKS;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t               state, state_n;
    logic [1:0]           bcnt;
    logic [15:0]          wcnt;
    logic [15:0]          n_words;
    logic [CPU_WIDTH-1:0] word;
    logic                 xfer;
    logic                 go;
    logic                 last_byte;
    logic                 last_word;
    logic                 oob;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    assign xfer      = in_valid && in_ready;
    assign go        = start && (state == IDLE || state == DONE || state == ERR);
    assign last_byte = xfer && state == DATA && bcnt == 2'd3;
    assign last_word = wcnt == n_words - 16'd1;
    // word indices past the memory depth are consumed but never written
    assign oob       = (wcnt >> MEM_ADDR_WIDTH) != 16'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = start ? HDR0 : IDLE;
            HDR0:      state_n = xfer ? HDR1 : HDR0;
            HDR1:      state_n = xfer ? (({in_data, n_words[7:0]} == 16'd0) ? TAIL : DATA) : HDR1;
            DATA:      state_n = (last_byte && last_word) ? TAIL : DATA;
`ifdef INST_LOADER_CHECKSUM_EN
            CKS:       state_n = xfer ? ((in_data == csum) ? DONE : ERR) : CKS;
`endif
            DONE, ERR: state_n = start ? HDR0 : state;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == HDR0 || state == HDR1 || state == DATA || state == CKS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wen   <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            bcnt      <= 2'd0;
            wcnt      <= 16'd0;
            n_words   <= 16'd0;
            word      <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
            err       <= 1'b0;
`endif
        end else begin
            mem_wen   <= 1'b0;
            // registered one cycle after DONE entry, so release trails the final write
            done      <= state == DONE && state_n == DONE;
            cpu_rst_n <= state == DONE && state_n == DONE;
`ifdef INST_LOADER_CHECKSUM_EN
            err       <= state == ERR && state_n == ERR;
`endif
            if (go) begin
                bcnt      <= 2'd0;
                wcnt      <= 16'd0;
                mem_waddr <= '0;
                ovf       <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
                csum      <= 8'd0;
`endif
            end
            if (state == HDR0 && xfer)
                n_words[7:0] <= in_data;
            if (state == HDR1 && xfer)
                n_words[15:8] <= in_data;
            if (state == DATA && xfer) begin
                bcnt <= bcnt + 2'd1;
                word <= {in_data, word[CPU_WIDTH-1:8]};
`ifdef INST_LOADER_CHECKSUM_EN
                csum <= csum ^ in_data;
`endif
            end
            if (last_byte) begin
                wcnt <= wcnt + 16'd1;
                if (oob)
                    ovf <= 1'b1;
                else begin
                    mem_wen   <= 1'b1;
                    mem_wdata <= {in_data, word[CPU_WIDTH-1:8]};
                    mem_waddr <= MEM_ADDR_WIDTH'(wcnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed checks of inst_loader (default depth and a 4-word instance for overflow).
module tb_inst_loader;

    logic        clk;
    logic        rst_n;
    logic        start1, start2;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        r1, wen1, crst1, done1, ovf1;
    logic        r2, wen2, crst2, done2, ovf2;
    logic [7:0]  wa1;
    logic [1:0]  wa2;
    logic [31:0] wd1, wd2;
`ifdef INST_LOADER_CHECKSUM_EN
    logic        err1, err2;
`endif
    int          n_chk, n_fail, wcnt1, wcnt2, snap;
    logic [7:0]  acc;

    inst_loader #(.CPU_WIDTH(32), .MEM_ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r1), .mem_wen(wen1), .mem_waddr(wa1), .mem_wdata(wd1),
        .cpu_rst_n(crst1), .done(done1), .ovf(ovf1)
`ifdef INST_LOADER_CHECKSUM_EN
        , .err(err1)
`endif
    );

    inst_loader #(.CPU_WIDTH(32), .MEM_ADDR_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r2), .mem_wen(wen2), .mem_waddr(wa2), .mem_wdata(wd2),
        .cpu_rst_n(crst2), .done(done2), .ovf(ovf2)
`ifdef INST_LOADER_CHECKSUM_EN
        , .err(err2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (wen1) wcnt1++;
        if (wen2) wcnt2++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit sel);
        @(negedge clk);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        acc = 8'h00;
    endtask

    task automatic send(input bit sel, input logic [7:0] d);
        int t;
        t = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!(sel ? r2 : r1) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_word(input bit sel, input logic [31:0] w, input int a, input bit exp_wen, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send(sel, w[8*i +: 8]);
            acc ^= w[8*i +: 8];
            if (i == 3) begin
                chk("wen", sel ? wen2 : wen1, exp_wen);
                if (exp_wen) begin
                    chk("waddr", sel ? 64'(wa2) : 64'(wa1), 64'(a));
                    chk("wdata", sel ? wd2 : wd1, w);
                    chk("cpu_rst_at_wen", sel ? crst2 : crst1, 1'b0);
                end
            end
            if (gap) @(negedge clk);
        end
    endtask

    task automatic finish_image(input bit sel);
`ifdef INST_LOADER_CHECKSUM_EN
        send(sel, acc);
`endif
        @(negedge clk);
        chk("done", sel ? done2 : done1, 1'b1);
        chk("cpu_rst_n", sel ? crst2 : crst1, 1'b1);
        chk("done_ready", sel ? r2 : r1, 1'b0);
    endtask

    task automatic chk_reset;
        chk("rst_ready", r1, 1'b0);
        chk("rst_wen", wen1, 1'b0);
        chk("rst_waddr", wa1, 8'd0);
        chk("rst_wdata", wd1, 32'd0);
        chk("rst_cpu_rst_n", crst1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_ovf", ovf1, 1'b0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; wcnt1 = 0; wcnt2 = 0; acc = 8'h00;
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", r1, 1'b0);

        // two-word image, back to back
        pulse(0);
        chk("hdr_ready", r1, 1'b1);
        send(0, 8'h02); send(0, 8'h00);
        load_word(0, 32'h0000_0013, 0, 1, 0);
        chk("done_mid", done1, 1'b0);
        load_word(0, 32'h0010_0093, 1, 1, 0);
        chk("done_at_last_wen", done1, 1'b0);
        finish_image(0);

        // empty image, restart from DONE
        pulse(0);
        chk("restart_done", done1, 1'b0);
        chk("restart_cpu", crst1, 1'b0);
        chk("restart_ready", r1, 1'b1);
        snap = wcnt1;
        send(0, 8'h00); send(0, 8'h00);
`ifdef INST_LOADER_CHECKSUM_EN
        chk("n0_cks_ready", r1, 1'b1);
`else
        chk("n0_ready", r1, 1'b0);
`endif
        finish_image(0);
        chk("n0_no_wen", 64'(wcnt1), 64'(snap));

        // same image with gaps on in_valid and a stray start mid-header
        pulse(0);
        snap = wcnt1;
        send(0, 8'h02);
        start1 = 1'b1;
        send(0, 8'h00);
        start1 = 1'b0;
        load_word(0, 32'h0000_0013, 0, 1, 1);
        load_word(0, 32'h0010_0093, 1, 1, 1);
        finish_image(0);
        chk("gap_wen_count", 64'(wcnt1), 64'(snap + 2));

        // 4-word memory, 5-word image
        pulse(1);
        snap = wcnt2;
        send(1, 8'h05); send(1, 8'h00);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) chk("ovf_before", ovf2, 1'b0);
            load_word(1, 32'h11 * (k + 1), k, k < 4, 0);
        end
        chk("ovf_after", ovf2, 1'b1);
        finish_image(1);
        chk("ovf_sticky", ovf2, 1'b1);
        chk("ovf_wen_count", 64'(wcnt2), 64'(snap + 4));

        // reset mid-load, then reload
        pulse(0);
        send(0, 8'h01); send(0, 8'h00);
        send(0, 8'h13); send(0, 8'h00);
        rst_n = 1'b0;
        #1;
        chk_reset();
        snap = wcnt1;
        repeat (3) @(negedge clk);
        chk("rst_no_wen", 64'(wcnt1), 64'(snap));
        rst_n = 1'b1;
        @(negedge clk);
        pulse(0);
        send(0, 8'h02); send(0, 8'h00);
        load_word(0, 32'h0000_0013, 0, 1, 0);
        load_word(0, 32'h0010_0093, 1, 1, 0);
        finish_image(0);

`ifdef INST_LOADER_CHECKSUM_EN
        // checksum mismatch then good restart
        pulse(0);
        send(0, 8'h01); send(0, 8'h00);
        load_word(0, 32'h0000_0013, 0, 1, 0);
        send(0, 8'h12);
        @(negedge clk);
        chk("err_set", err1, 1'b1);
        chk("err_cpu", crst1, 1'b0);
        chk("err_done", done1, 1'b0);
        pulse(0);
        chk("err_clear", err1, 1'b0);
        send(0, 8'h01); send(0, 8'h00);
        load_word(0, 32'h0000_0013, 0, 1, 0);
        finish_image(0);
        chk("err_after_ok", err1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
